// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table checker.
//   - FSM state encodings (localparam constants)
//   - Sizing helpers for the vector count and settle counter width
package tt_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Number of input vectors swept for an n-input DUT.
    function automatic int unsigned num_vec(input int unsigned n_in);
        return 2 ** n_in;
    endfunction

    // Width of the settle counter for a given hold length.
    function automatic int unsigned settle_w(input int unsigned settle);
        return $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times the HOLD phase of each vector.
// Ports:
//   clk     in  rising-edge clock
//   rst     in  asynchronous active-high reset
//   load    in  reload the counter with LOAD_VAL
//   en      in  decrement by one (stops at zero)
//   expired out counter has reached zero
module tt_settle_timer #(
    parameter int unsigned     W        = 2,
    parameter logic [W-1:0]    LOAD_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Self-running response checker. Sweeps every N_IN-bit vector into a combinational
// DUT, holds each for SETTLE cycles, samples f_i on the following cycle and compares
// it with EXPECTED[vector].
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin a sweep (ignored while busy)
//   vec_o               vector driven to the DUT (MSB = first DUT input)
//   f_i                 DUT output under test
//   busy, done, pass    sweep status; pass valid when done
//   err_count           number of mismatching vectors
//   first_fail_valid    at least one mismatch seen
//   first_fail_vec      lowest-index failing vector
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int unsigned             N_IN     = 4,
    parameter int unsigned             SETTLE   = 2,
    parameter logic [(2**N_IN)-1:0]    EXPECTED = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec_o,
    input  logic            f_i,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam int unsigned     NUM_VEC  = num_vec(N_IN);
    localparam int unsigned     SETTLE_W = settle_w(SETTLE);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NUM_VEC - 1);

    logic [1:0]      state_q, state_d;
    logic [N_IN-1:0] vec_d;
    logic [N_IN:0]   err_d;
    logic            ffv_d;
    logic [N_IN-1:0] ffvec_d;
    logic            busy_d, done_d, pass_d;
    logic            timer_load, timer_en, timer_expired;
    logic            mismatch;

    // Timer counts SETTLE-1 down to 0: SETTLE edges in HOLD.
    tt_settle_timer #(
        .W        (SETTLE_W),
        .LOAD_VAL (SETTLE_W'(SETTLE - 1))
    ) u_settle (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // Case inequality so an X/Z response counts as a failure in 4-state simulation.
    assign mismatch = (f_i !== EXPECTED[vec_o]);

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_o;
        err_d      = err_count;
        ffv_d      = first_fail_valid;
        ffvec_d    = first_fail_vec;
        busy_d     = busy;
        done_d     = done;
        pass_d     = pass;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_HOLD;
                    vec_d      = '0;
                    err_d      = '0;
                    ffv_d      = 1'b0;
                    ffvec_d    = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    timer_load = 1'b1;
                end
            end
            ST_HOLD: begin
                timer_en = 1'b1;
                if (timer_expired) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_d = err_count + 1'b1;
                    if (!first_fail_valid) begin
                        ffv_d   = 1'b1;
                        ffvec_d = vec_o;
                    end
                end
                if (vec_o == LAST_VEC) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    vec_d      = vec_o + 1'b1;
                    timer_load = 1'b1;
                    state_d    = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            vec_o            <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
        end else begin
            state_q          <= state_d;
            vec_o            <= vec_d;
            err_count        <= err_d;
            first_fail_valid <= ffv_d;
            first_fail_vec   <= ffvec_d;
            busy             <= busy_d;
            done             <= done_d;
            pass             <= pass_d;
        end
    end

endmodule
